// File: rtl/audio_pkg.sv
// Shared types and default timing constants for the I2S audio capture path.
// Pulled in by the capture controller and its sample FIFO.
package audio_pkg;

    localparam int AUD_WORD_W = 64;

    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_FRAME_MIN  = 64;
    localparam int DEF_FRAME_MAX  = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } cap_state_e;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock sample FIFO with registered read data.
// Full/empty come from read/write pointers that carry one extra wrap bit.
module sync_fifo_sc
    import audio_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = AUD_WORD_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Same index with differing wrap bits means the write side has lapped the read side.
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_fill  = wr_ptr - rd_ptr;

    assign do_wr = i_wr_en && !o_full && !i_flush;
    assign do_rd = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_rd_data <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr    <= rd_ptr + (AW+1)'(1);
                o_rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/iis_audio_capture_ctrl.sv
// I2S capture sequencer: frame-interval lock detection, sample buffering,
// and fixed-length burst draining to the DMA write engine over req/ack.
module iis_audio_capture_ctrl
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int FRAME_MIN  = DEF_FRAME_MIN,
    parameter int FRAME_MAX  = DEF_FRAME_MAX
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_smp_valid,
    input  logic [AUD_WORD_W-1:0] i_smp_data,
    output logic                  o_dma_req,
    input  logic                  i_dma_ack,
    output logic                  o_dma_valid,
    output logic [AUD_WORD_W-1:0] o_dma_data,
    output logic                  o_locked,
    output logic                  o_overflow,
    output logic [31:0]           o_frame_cnt
);

    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INT_W  = cnt_width(FRAME_MAX + 1);
    localparam int GOOD_W = cnt_width(LOCK_CNT);
    localparam int BEAT_W = cnt_width(BURST_LEN);

    localparam logic [INT_W-1:0]  INT_MIN    = INT_W'(FRAME_MIN);
    localparam logic [INT_W-1:0]  INT_MAX    = INT_W'(FRAME_MAX);
    localparam logic [INT_W-1:0]  INT_SAT    = INT_W'(FRAME_MAX + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK  = GOOD_W'(LOCK_CNT);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [FILL_W-1:0] BURST_FILL = FILL_W'(BURST_LEN);

    cap_state_e state_q;
    cap_state_e state_d;

    logic [INT_W-1:0]      int_cnt;
    logic [GOOD_W-1:0]     good_cnt;
    logic                  have_ref;
    logic                  in_window;
    logic                  hit_timeout;

    logic                  accept;
    logic                  fifo_flush;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FILL_W-1:0]     fifo_fill;
    logic [AUD_WORD_W-1:0] fifo_rd_data;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  rd_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_smp_valid) begin
            int_cnt <= '0;
        end else if (int_cnt != INT_SAT) begin
            int_cnt <= int_cnt + INT_W'(1);
        end
    end

    // A strobe only measures a real interval once a previous strobe was seen while enabled.
    assign in_window   = have_ref && (int_cnt >= INT_MIN) && (int_cnt <= INT_MAX);
    assign hit_timeout = !i_smp_valid && (int_cnt == INT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            have_ref <= 1'b0;
            good_cnt <= '0;
            o_locked <= 1'b0;
        end else begin
            if (i_smp_valid) begin
                have_ref <= 1'b1;
                if (!in_window) begin
                    good_cnt <= '0;
                end else if (good_cnt != GOOD_LOCK) begin
                    good_cnt <= good_cnt + GOOD_W'(1);
                end
            end else if (hit_timeout) begin
                good_cnt <= '0;
            end
            o_locked <= (good_cnt == GOOD_LOCK);
        end
    end

    assign accept     = i_smp_valid && o_locked && i_enable;
    assign fifo_flush = !i_enable && (state_q != ST_BURST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            if (!i_enable) begin
                o_overflow <= 1'b0;
            end else if (accept && fifo_full) begin
                o_overflow <= 1'b1;
            end
            if (accept && !fifo_full) begin
                o_frame_cnt <= o_frame_cnt + 32'd1;
            end
        end
    end

    sync_fifo_sc #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AUD_WORD_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (fifo_flush),
        .i_wr_en   (accept),
        .i_wr_data (i_smp_data),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_rd_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_fill    (fifo_fill)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_enable && (fifo_fill >= BURST_FILL)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (i_dma_ack) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_cnt == LAST_BEAT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_dma_req = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            ST_REQ:   o_dma_req = 1'b1;
            ST_BURST: fifo_pop  = !fifo_empty;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || (state_q != ST_BURST)) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    // FIFO read data lands one cycle after the pop; the output stage adds one more register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pend     <= 1'b0;
            o_dma_valid <= 1'b0;
            o_dma_data  <= '0;
        end else begin
            rd_pend     <= fifo_pop;
            o_dma_valid <= rd_pend;
            o_dma_data  <= rd_pend ? fifo_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_iis_audio_capture_ctrl.sv
// Scoreboard bench for iis_audio_capture_ctrl: accepted samples are queued
// as they are driven and compared against the DMA burst output.
module tb_iis_audio_capture_ctrl;
    import audio_pkg::*;

    localparam int FIFO_DEPTH = DEF_FIFO_DEPTH;
    localparam int BURST_LEN  = DEF_BURST_LEN;
    localparam int LOCK_CNT   = DEF_LOCK_CNT;
    localparam int FRAME_MIN  = DEF_FRAME_MIN;
    localparam int FRAME_MAX  = DEF_FRAME_MAX;

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_enable;
    logic                  i_smp_valid;
    logic [AUD_WORD_W-1:0] i_smp_data;
    logic                  o_dma_req;
    logic                  i_dma_ack;
    logic                  o_dma_valid;
    logic [AUD_WORD_W-1:0] o_dma_data;
    logic                  o_locked;
    logic                  o_overflow;
    logic [31:0]           o_frame_cnt;

    iis_audio_capture_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_smp_valid (i_smp_valid),
        .i_smp_data  (i_smp_data),
        .o_dma_req   (o_dma_req),
        .i_dma_ack   (i_dma_ack),
        .o_dma_valid (o_dma_valid),
        .o_dma_data  (o_dma_data),
        .o_locked    (o_locked),
        .o_overflow  (o_overflow),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [AUD_WORD_W-1:0] exp_q [$];
    int  m_good   = 0;
    int  m_fill   = 0;
    int  m_frames = 0;
    bit  m_ref    = 1'b0;
    bit  m_en     = 1'b0;
    bit  m_ovf    = 1'b0;
    int  last_strobe = 0;
    int  sid = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] pat(input int n);
        return {32'(n) ^ 32'hC0DE_0000, 32'h1234_5678 + 32'(n)};
    endfunction

    // Every burst word must match the oldest sample the model expects to be stored.
    always @(negedge i_clk) begin
        if (o_dma_valid === 1'b1) begin
            if (exp_q.size() == 0) checkOutput("dma_extra_word", 64'd1, 64'd0);
            else checkOutput("dma_data", o_dma_data, exp_q.pop_front());
        end
    end

    // Drives one strobe so that it lands gap cycles after the previous one, and updates the model.
    task automatic applyStimulus(input int gap, input logic [63:0] d);
        int interval;
        bit acc;
        while (cyc < last_strobe + gap - 1) begin @(posedge i_clk); #1; end
        i_smp_valid = 1'b1;
        i_smp_data  = d;
        @(posedge i_clk); #1;
        i_smp_valid = 1'b0;
        i_smp_data  = '0;
        interval    = cyc - last_strobe;
        last_strobe = cyc;
        if (interval - 1 > FRAME_MAX) m_good = 0;
        acc = m_en && (m_good == LOCK_CNT);
        if (acc) begin
            if (m_fill < FIFO_DEPTH) begin
                exp_q.push_back(d);
                m_fill++;
                m_frames++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_en) begin
            if (m_ref && (interval - 1 >= FRAME_MIN) && (interval - 1 <= FRAME_MAX)) begin
                if (m_good < LOCK_CNT) m_good++;
            end else begin
                m_good = 0;
            end
            m_ref = 1'b1;
        end
    endtask

    task automatic sendSamples(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(128, pat(sid));
            sid++;
        end
    endtask

    task automatic relock(input int first_gap);
        applyStimulus(first_gap, pat(sid)); sid++;
        sendSamples(LOCK_CNT - 1);
        repeat (2) begin @(posedge i_clk); #1; end
        checkOutput("locked_one_short", o_locked, 1'b0);
        sendSamples(1);
        checkOutput("locked_same_cycle", o_locked, 1'b0);
        @(posedge i_clk); #1;
        checkOutput("locked_rise", o_locked, 1'b1);
        checkOutput("frame_cnt_lock", o_frame_cnt, m_frames);
    endtask

    task automatic disableCapture();
        i_enable = 1'b0;
        m_en     = 1'b0;
        m_good   = 0;
        m_ref    = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic startBurst(output bit ok);
        int waitc = 0;
        while (!o_dma_req && waitc < 300) begin @(posedge i_clk); #1; waitc++; end
        checkOutput("dma_req_wait", o_dma_req, 1'b1);
        ok = o_dma_req;
        if (ok) begin
            i_dma_ack = 1'b1;
            @(posedge i_clk); #1;
            i_dma_ack = 1'b0;
            m_fill -= BURST_LEN;
        end
    endtask

    task automatic serviceBurst(input int drop_at);
        bit ok;
        int first;
        int last;
        int nvalid;
        startBurst(ok);
        if (!ok) return;
        first = -1; last = -1; nvalid = 0;
        checkOutput("dma_req_after_ack", o_dma_req, 1'b0);
        for (int k = 1; k <= BURST_LEN + 4; k++) begin
            @(posedge i_clk); #1;
            if (k == drop_at) disableCapture();
            if (o_dma_valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = k;
                last = k;
            end else begin
                checkOutput("dma_data_idle", o_dma_data, 64'd0);
            end
        end
        checkOutput("dma_first_latency", first, 2);
        checkOutput("dma_beats", nvalid, BURST_LEN);
        checkOutput("dma_contiguous", last - first + 1, BURST_LEN);
        checkOutput("sb_left", exp_q.size(), m_fill);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int cnt;
        int t_last;
        i_rst = 1'b1; i_enable = 1'b0; i_smp_valid = 1'b0; i_smp_data = '0; i_dma_ack = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
        checkOutput("rst_locked", o_locked, 1'b0);
        checkOutput("rst_req", o_dma_req, 1'b0);
        checkOutput("rst_valid", o_dma_valid, 1'b0);
        checkOutput("rst_data", o_dma_data, 64'd0);
        checkOutput("rst_overflow", o_overflow, 1'b0);
        checkOutput("rst_frame_cnt", o_frame_cnt, 32'd0);
        i_rst = 1'b0;
        i_enable = 1'b1;
        m_en = 1'b1;
        last_strobe = cyc;

        $display("[TB] lock acquisition and first burst");
        relock(128);
        sendSamples(1);
        checkOutput("first_accept", o_frame_cnt, 32'd1);
        sendSamples(BURST_LEN - 1);
        checkOutput("frame_cnt_8", o_frame_cnt, m_frames);
        serviceBurst(0);

        $display("[TB] loss of signal");
        t_last = last_strobe;
        while (cyc < t_last + FRAME_MAX + 1) begin @(posedge i_clk); #1; end
        checkOutput("lock_before_timeout", o_locked, 1'b1);
        @(posedge i_clk); #1;
        checkOutput("lock_after_timeout", o_locked, 1'b0);
        relock(5000);

        $display("[TB] overflow with ack withheld");
        sendSamples(20);
        checkOutput("ovf_set", o_overflow, m_ovf);
        checkOutput("ovf_frame_cnt", o_frame_cnt, m_frames);
        checkOutput("ovf_stored", exp_q.size(), FIFO_DEPTH);
        checkOutput("ovf_req_pending", o_dma_req, 1'b1);
        disableCapture();
        @(posedge i_clk); #1;
        exp_q.delete();
        m_fill = 0;
        checkOutput("ovf_cleared", o_overflow, m_ovf);
        checkOutput("dis_locked", o_locked, 1'b0);
        @(posedge i_clk); #1;
        checkOutput("dis_req", o_dma_req, 1'b0);
        i_dma_ack = 1'b1;
        @(posedge i_clk); #1;
        i_dma_ack = 1'b0;
        cnt = 0;
        repeat (6) begin @(posedge i_clk); #1; if (o_dma_valid) cnt++; end
        checkOutput("stray_ack_ignored", cnt, 0);

        $display("[TB] disable during burst");
        i_enable = 1'b1;
        m_en = 1'b1;
        relock(128);
        sendSamples(BURST_LEN + 2);
        serviceBurst(3);
        cnt = 0;
        repeat (20) begin @(posedge i_clk); #1; if (o_dma_req) cnt++; end
        checkOutput("dis_no_req", cnt, 0);
        exp_q.delete();
        m_fill = 0;
        i_enable = 1'b1;
        m_en = 1'b1;
        relock(128);
        sendSamples(BURST_LEN);
        serviceBurst(0);

        $display("[TB] reset during burst");
        sendSamples(BURST_LEN);
        startBurst(ok);
        repeat (4) begin @(posedge i_clk); #1; end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checkOutput("rstb_valid", o_dma_valid, 1'b0);
        checkOutput("rstb_data", o_dma_data, 64'd0);
        checkOutput("rstb_req", o_dma_req, 1'b0);
        checkOutput("rstb_locked", o_locked, 1'b0);
        checkOutput("rstb_overflow", o_overflow, 1'b0);
        checkOutput("rstb_frame_cnt", o_frame_cnt, 32'd0);
        i_rst = 1'b0;
        m_good = 0; m_ref = 1'b0; m_fill = 0; m_frames = 0; m_ovf = 1'b0;
        exp_q.delete();
        relock(128);
        sendSamples(1);
        checkOutput("post_rst_accept", o_frame_cnt, m_frames);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
